// File: rtl/control_riesgos_pkg.sv
// Shared definitions for the pipeline hazard controller: register-index
// width, wait-counter width and the controller state encoding.
package control_riesgos_pkg;

  localparam int REG_W  = 5;  // MIPS register index width
  localparam int WAIT_W = 4;  // enough for a memory timeout of up to 15 cycles

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2,
    ST_UNUSED   = 2'd3
  } estado_t;

endpackage

// File: rtl/control_riesgos_deteccion_carga_uso.sv
// Pure combinational load-use detector: the LW in EX writes a register that
// the instruction in ID is about to read. Register 0 never creates a hazard.
module deteccion_carga_uso
  import control_riesgos_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use
);

  // Compare the load destination against both ID source operands
  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/control_riesgos.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, branch/jump
// flushes, data-memory wait with timeout, and a saturating stall counter.
module control_riesgos
  import control_riesgos_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  estado_t           state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [WAIT_W:0]   wait_inc;
  logic              mem_err_reg, mem_err_next;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic              load_use;
  logic              run_rules;

  deteccion_carga_uso u_carga_uso (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  // One extra bit so the compare against MEM_TIMEOUT=15 cannot overflow
  assign wait_inc = {1'b0, wait_reg} + (WAIT_W+1)'(1);

  // Next-state and pipeline control; memory stall outranks branch, which
  // outranks load-use, which outranks jump (a stalled jump retries next cycle)
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    state_next   = state_reg;
    wait_next    = wait_reg;
    mem_err_next = mem_err_reg;
    run_rules    = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          state_next  = ST_MEM_WAIT;
          wait_next   = '0;
        end else begin
          run_rules = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          run_rules  = 1'b1;
          state_next = ST_RUN;
          wait_next  = '0;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          if (wait_inc == (WAIT_W+1)'(MEM_TIMEOUT)) begin
            state_next   = ST_TIMEOUT;
            wait_next    = '0;
            mem_err_next = 1'b1;
          end else begin
            wait_next = wait_inc[WAIT_W-1:0];
          end
        end
      end
      ST_TIMEOUT: begin
        // The access is abandoned: EX/MEM advances, hazards still apply
        run_rules  = 1'b1;
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
        wait_next  = '0;
      end
    endcase

    if (run_rules) begin
      if (ex_br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
    end

    // While reset is held the pipeline free-runs with no flushes
    if (!rst_n) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
    end
  end

  // State, wait counter, sticky error and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      wait_reg      <= '0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      mem_err_reg <= mem_err_next;
      if (!pc_write && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign mem_err   = mem_err_reg;
  assign stall_cnt = stall_cnt_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_control_riesgos.sv
// Bench for control_riesgos: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_control_riesgos;

  localparam int TO   = 15;
  localparam int CW   = 6;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_uses_rt = 0, id_jump = 0, ex_memread = 0, ex_br_taken = 0;
  logic          mem_req = 0, mem_ack = 0;
  logic          pc_write, ifid_write, idex_write, exmem_write;
  logic          ifid_flush, idex_flush, mem_err;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;

  // Behavioural model: "waiting" and cycles waited, one-shot timeout cycle
  bit m_waiting = 0;
  int m_waited  = 0;
  bit m_tocycle = 0;
  bit m_err     = 0;
  int m_stalls  = 0;

  control_riesgos #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0;
    ex_memread = 0; ex_rt = 0; ex_br_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  // Asynchronous reset clears the model as well
  always @(negedge rst_n) begin
    m_waiting = 0; m_waited = 0; m_tocycle = 0; m_err = 0; m_stalls = 0;
  end

  // Per-cycle comparison against the model, then advance the model
  initial begin
    bit lu, hz, e_pc, e_ifw, e_idw, e_exw, e_iff, e_idf;
    int e_st;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_pc_write", pc_write, 1);
        chk("rst_exmem_write", exmem_write, 1);
        chk("rst_flushes", {ifid_flush, idex_flush}, 0);
      end else begin
        lu = ex_memread && ex_rt != 0 &&
             (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        e_pc = 1; e_ifw = 1; e_idw = 1; e_exw = 1; e_iff = 0; e_idf = 0;
        hz = 1;
        if (!m_tocycle && ((m_waiting && !mem_ack) || (!m_waiting && mem_req && !mem_ack))) begin
          e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0; hz = 0;
        end
        if (hz) begin
          if (ex_br_taken) begin e_iff = 1; e_idf = 1; end
          else if (lu) begin e_pc = 0; e_ifw = 0; e_idf = 1; end
          else if (id_jump) e_iff = 1;
        end
        e_st = m_tocycle ? 2 : (m_waiting ? 1 : 0);
        chk("state", state, e_st);
        chk("pc_write", pc_write, e_pc);
        chk("ifid_write", ifid_write, e_ifw);
        chk("idex_write", idex_write, e_idw);
        chk("exmem_write", exmem_write, e_exw);
        chk("ifid_flush", ifid_flush, e_iff);
        chk("idex_flush", idex_flush, e_idf);
        chk("mem_err", mem_err, m_err);
        chk("stall_cnt", stall_cnt, m_stalls);
        // advance model to the state after the coming rising edge
        if (!e_pc && m_stalls < MAXC) m_stalls++;
        if (m_tocycle) m_tocycle = 0;
        else if (m_waiting) begin
          if (mem_ack) begin m_waiting = 0; m_waited = 0; end
          else begin
            m_waited++;
            if (m_waited == TO) begin
              m_waiting = 0; m_waited = 0; m_tocycle = 1; m_err = 1;
            end
          end
        end else if (mem_req && !mem_ack) begin
          m_waiting = 1; m_waited = 0;
        end
      end
    end
  end

  initial begin
    // Reset held with hazard-provoking inputs: outputs must stay free-running
    mem_req = 1; ex_memread = 1; ex_rt = 8; id_rs = 8;
    #2;
    chk("reset_pc_write", pc_write, 1);
    chk("reset_idex_flush", idex_flush, 0);
    chk("reset_state", state, 0);
    idle();
    #10 rst_n = 1;
    step();

    // Load-use on r8: one bubble, counter 0 -> 1
    ex_memread = 1; ex_rt = 8; id_rs = 8;
    #1;
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    chk("lu_idex_flush", idex_flush, 1);
    chk("lu_cnt_before", stall_cnt, 0);
    step();
    idle();
    #1;
    chk("lu_cnt_after", stall_cnt, 1);
    chk("lu_clear_pc", pc_write, 1);
    step();

    // Load into r0 never stalls
    ex_memread = 1; ex_rt = 0; id_rs = 0;
    #1;
    chk("r0_writes", {pc_write, ifid_write, idex_write, exmem_write}, 4'hF);
    step();

    // Taken branch beats load-use and jump
    ex_br_taken = 1; ex_memread = 1; ex_rt = 8; id_rs = 8; id_jump = 1;
    #1;
    chk("br_flushes", {ifid_flush, idex_flush}, 2'b11);
    chk("br_pc_write", pc_write, 1);
    step();
    idle();
    #1;
    chk("br_cnt", stall_cnt, 1);

    // Memory access acknowledged three cycles after the request
    mem_req = 1;
    #1;
    chk("mw_run_pc", pc_write, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) mem_ack = 1;
      chk("mw_state", state, 1);
      if (i < 2) chk("mw_writes", {pc_write, ifid_write, idex_write, exmem_write}, 0);
    end
    #1;
    chk("mw_ack_pc", pc_write, 1);
    step();
    idle();
    chk("mw_back_run", state, 0);
    chk("mw_cnt", stall_cnt, 4);

    // No acknowledge: timeout after 15 wait cycles, sticky error
    mem_req = 1;
    for (int i = 0; i < TO; i++) begin
      step();
      chk("to_wait_state", state, 1);
    end
    step();
    chk("to_state", state, 2);
    chk("to_err", mem_err, 1);
    chk("to_exmem", exmem_write, 1);
    chk("to_pc", pc_write, 1);
    step();
    mem_req = 0;
    #1;
    chk("to_back_run", state, 0);
    chk("to_err_sticky", mem_err, 1);
    chk("to_cnt", stall_cnt, 20);

    // Randomized traffic, small register range to provoke hazards often
    for (int n = 0; n < 600; n++) begin
      step();
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      id_uses_rt  = 1'($urandom_range(0, 1));
      ex_memread  = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 6) == 0);
      id_jump     = ($urandom_range(0, 6) == 0);
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ack     = ($urandom_range(0, 9) < 2);
    end

    // Asynchronous reset in the middle of a memory wait
    step();
    idle();
    mem_ack = 1;
    step();
    step();
    mem_ack = 0; mem_req = 1;
    step();
    step();
    chk("ar_in_wait", state, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_state", state, 0);
    chk("ar_cnt", stall_cnt, 0);
    chk("ar_err", mem_err, 0);
    chk("ar_pc", pc_write, 1);
    idle();
    rst_n = 1;
    step();
    chk("ar_post_state", state, 0);
    chk("ar_post_cnt", stall_cnt, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_riesgos.md
CONTROL_RIESGOS -- requirements
Module: control_riesgos

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max cycles waited for MEM_ACK (1..15).
REQ-002 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 ID_RS, ID_RT  in  5 each  source register fields of the instruction in ID.
REQ-006 ID_USES_RT  in  1  ID instruction reads RT as an operand (R-type, BEQ, SW).
REQ-007 ID_JUMP  in  1  ID instruction is J (decoded Jump bit).
REQ-008 EX_MEMREAD  in  1  instruction in EX is LW; EX_RT  in  5  its destination.
REQ-009 EX_BR_TAKEN  in  1  BEQ in EX resolved taken.
REQ-010 MEM_REQ  in  1  instruction in MEM has MemRead or MemWrite; MEM_ACK  in  1  data memory done.
REQ-011 PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE  out  1 each  pipeline register enables.
REQ-012 IFID_FLUSH, IDEX_FLUSH  out  1 each  force register to a NOP/bubble (all control zero).
REQ-013 MEM_ERR  out  1  sticky memory-timeout flag; STALL_CNT  out  CNT_W  stall-cycle counter.
REQ-014 STATE  out  2  current FSM state: RUN=0, MEM_WAIT=1, TIMEOUT=2.

Function
REQ-015 Outputs are combinational from registered state and current inputs; decisions act in the same cycle the condition is present.
REQ-016 Load-use hazard = EX_MEMREAD & EX_RT!=0 & (EX_RT==ID_RS | (ID_USES_RT & EX_RT==ID_RT)).
REQ-017 RUN, load-use only: PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1, others write enabled; exactly one bubble per hazard.
REQ-018 RUN, EX_BR_TAKEN: IFID_FLUSH=1, IDEX_FLUSH=1, PC_WRITE=1; suppresses any simultaneous load-use stall or jump.
REQ-019 RUN, ID_JUMP (no taken branch): IFID_FLUSH=1, PC_WRITE=1, IDEX proceeds normally.
REQ-020 RUN, MEM_REQ & !MEM_ACK: all four *_WRITE=0, no flushes, next state MEM_WAIT; overrides branch, jump and load-use.
REQ-021 RUN, MEM_REQ & MEM_ACK same cycle: no wait; normal RUN rules apply.
REQ-022 MEM_WAIT: all *_WRITE=0, flushes 0, wait counter increments each cycle.
REQ-023 MEM_WAIT with MEM_ACK: that cycle behaves as RUN (hazard rules evaluated), next state RUN, wait counter cleared.
REQ-024 MEM_WAIT, wait counter reaching MEM_TIMEOUT without ACK: next state TIMEOUT.
REQ-025 TIMEOUT: one cycle; MEM_ERR set (sticky until reset), EXMEM_WRITE=1 with access abandoned, other rules as RUN; next state RUN.
REQ-026 STALL_CNT increments every cycle PC_WRITE=0; saturates at all-ones, never wraps.
REQ-027 Unused STATE encoding 3 returns to RUN next cycle with all writes enabled.

Reset
REQ-028 RST_N low: state RUN, wait counter 0, MEM_ERR 0, STALL_CNT 0, immediately and independent of CLK.
REQ-029 During reset outputs are PC_WRITE=IFID_WRITE=IDEX_WRITE=EXMEM_WRITE=1, flushes 0.
REQ-030 Reset asserted mid MEM_WAIT abandons the wait; first post-reset cycle is RUN.

Structure
REQ-031 State encodings and the 5-bit register-index width live in the shared processor package, reused by the pipeline top.
REQ-032 One sub-module natural: deteccion_carga_uso (pure combinational load-use compare), instanced once.
REQ-033 Single always_ff for state, wait counter, MEM_ERR, STALL_CNT; single always_comb for outputs.

Verification
REQ-034 EX LW EX_RT=8, ID_RS=8: one cycle PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1; STALL_CNT 0->1; next cycle clear.
REQ-035 EX LW EX_RT=0, ID_RS=0: no stall, all writes 1.
REQ-036 EX_BR_TAKEN=1 with same-cycle load-use and ID_JUMP: IFID_FLUSH=IDEX_FLUSH=1, PC_WRITE=1, STALL_CNT unchanged.
REQ-037 MEM_REQ=1, MEM_ACK after 3 cycles: STATE=1 for 3 cycles, all writes 0, STALL_CNT +3, RUN after ACK.
REQ-038 MEM_REQ=1, no ACK, MEM_TIMEOUT=15: STATE=2 after 15 wait cycles, MEM_ERR=1 and stays 1, then RUN.
REQ-039 RST_N pulsed low mid MEM_WAIT (asynchronous, between edges): STATE=0, STALL_CNT=0, MEM_ERR=0 immediately.
